lif_array: RTL
==============

# lif_array

Parametrised array of N leaky integrate-and-fire neurons sharing one runtime-configurable parameter set: threshold, leak shift, refractory period and reset mode. Each neuron integrates its own input current on every step strobe, with a saturating accumulator. On crossing threshold it emits a registered one-cycle spike, then resets or subtracts its membrane state and optionally holds for a refractory period. It is the multi-channel successor to the single fixed-parameter neuron and feeds the spike-routing logic downstream.

## Interface
- WIDTH, 8, bit width of current, state, threshold
- N, 4, number of neurons
- REFRAC_W, 4, width of refractory period and per-neuron counters
- THRESH_INIT, 200, threshold value after reset
- clk  input  1  clock; all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- en  input  1  step strobe; neurons update only on edges where en=1
- current  input  N*WIDTH  unsigned input current; neuron i uses bits [i*WIDTH +: WIDTH]
- cfg_we  input  1  config write enable
- cfg_addr  input  2  config register select
- cfg_data  input  WIDTH  config write data
- state  output  N*WIDTH  registered membrane state per neuron
- spike  output  N  registered spike flags, one per neuron
- spike_any  output  1  registered OR of all spike bits

## Operation
- Config registers, written on clk when cfg_we=1:
  - addr 0 threshold, WIDTH bits, reset THRESH_INIT.
  - addr 1 leak shift, low clog2(WIDTH) bits, reset 1.
  - addr 2 refractory period, low REFRAC_W bits, reset 0.
  - addr 3 mode, bit0 only: 0 = reset-to-zero, 1 = subtract-threshold; reset 0.
- Unused cfg_data bits are ignored.
- Per neuron i, on an edge with en=1 and refrac_cnt[i]≠0:
  - refrac_cnt[i] decrements.
  - state[i] holds; current is ignored.
  - spike[i] ← 0.
- Per neuron i, on an edge with en=1 and refrac_cnt[i]=0:
  - sum = current[i] + (state[i] >> leak), computed at WIDTH+1 bits.
  - sum saturates to 2^WIDTH−1.
  - If sum ≥ threshold: spike[i] ← 1; refrac_cnt[i] ← refractory period; state[i] ← 0 in mode 0, or sum−threshold in mode 1.
  - Otherwise: spike[i] ← 0; state[i] ← sum.
- Leak shift 0 means no leak (pure integrator).
- Threshold 0 fires on every non-refractory step.
- On an edge with en=0: state and refractory counters hold; spike ← 0.
- spike_any is registered alongside spike, equal to the OR of the next spike vector.
- Neurons are fully independent except for the shared config.

## Timing
- Reset (asynchronous, reset_n low, takes effect without a clock edge):
  - state=0, spike=0, spike_any=0, all refrac_cnt=0.
  - Config registers return to their reset values.
- Release of reset is synchronous to clk; the first step is the first en=1 edge after deassertion.
- Latency: the spike and updated state for step k appear one clock after the en edge of step k, and are valid until the next edge.
- A spike pulse lasts exactly one clock even if en is held high.
- A config write and a step on the same edge: the step uses the old config value; the new value applies from the next edge.
- Changing the refractory period does not alter counters already running.
- Reset asserted mid-refractory or mid-spike clears everything immediately; no residual spike appears after release.

## Test plan
- Defaults, current0=100, en=1 every cycle -> state0 = 100,150,175,187,193,196,198,199,199…; spike0 never asserts.
- Defaults, current0=120 -> state0 = 120,180,0 with spike0=1 on the third step; the pattern repeats every 3 steps; spike_any tracks spike0; other neurons with current 0 stay 0.
- Write threshold=255 and leak=0, current0=200 -> 200; then saturated sum 255 ≥ 255 gives spike, state 0. Verify there is no wrap to 144.
- Mode=1, refractory=2, threshold 200, leak 1, current0=120 -> 120,180, then spike with state 10. State holds 10 for two steps with spike 0. Then 125,182, then spike with state 11.
- en toggling 1,0,1 with current0=120 -> state advances only on en=1 edges and spike drops on en=0 edges. A threshold write on the same edge as a step is ignored for that step.
- Pull reset_n low between clock edges during refractory with spike high -> state, spike, spike_any and counters go to 0 immediately and config reads back defaults. After release, behaviour matches the scenario 2 sequence.

Source files
------------

// File: rtl/lif_array_if.sv
// Step/config/output bundle for lif_array: the driver (master) issues step
// strobes, currents and config writes; the neuron array (slave) returns state and spikes.
interface lif_array_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4
);
   logic                 en;
   logic [N*WIDTH-1:0]   current;
   logic                 cfg_we;
   logic [1:0]           cfg_addr;
   logic [WIDTH-1:0]     cfg_data;
   logic [N*WIDTH-1:0]   state;
   logic [N-1:0]         spike;
   logic                 spike_any;

   modport master (
      output en, current, cfg_we, cfg_addr, cfg_data,
      input  state, spike, spike_any
   );

   modport slave (
      input  en, current, cfg_we, cfg_addr, cfg_data,
      output state, spike, spike_any
   );
endinterface

// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons sharing one runtime config
// (threshold, leak shift, refractory period, reset mode); saturating integration.
module lif_array #(
   parameter int WIDTH       = 8,
   parameter int N           = 4,
   parameter int REFRAC_W    = 4,
   parameter int THRESH_INIT = 200
)(
   input logic        clk,
   input logic        reset_n,
   lif_array_if.slave bus
);

   localparam int LEAK_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}};

   function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      sat_add = s[WIDTH] ? SAT_MAX : s[WIDTH-1:0];
   endfunction

   logic [WIDTH-1:0]    thresh_r;
   logic [LEAK_W-1:0]   leak_r;
   logic [REFRAC_W-1:0] refrac_r;
   logic                mode_r;
   logic [N-1:0]        spike_nxt_s;
   logic                spike_any_r;

   // Shared configuration registers; a write lands after any same-edge step used the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         thresh_r <= WIDTH'(THRESH_INIT);
         leak_r   <= LEAK_W'(1);
         refrac_r <= {REFRAC_W{1'b0}};
         mode_r   <= 1'b0;
      end else if (bus.cfg_we) begin
         case (bus.cfg_addr)
            2'd0:    thresh_r <= bus.cfg_data;
            2'd1:    leak_r   <= LEAK_W'(bus.cfg_data);
            2'd2:    refrac_r <= REFRAC_W'(bus.cfg_data);
            2'd3:    mode_r   <= bus.cfg_data[0];
            default: mode_r   <= mode_r;
         endcase
      end else begin
         thresh_r <= thresh_r;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_neuron
      logic [WIDTH-1:0]    state_r;
      logic [REFRAC_W-1:0] cnt_r;
      logic                spike_r;
      logic [WIDTH-1:0]    sum_s;
      logic [WIDTH-1:0]    state_nxt_s;
      logic [REFRAC_W-1:0] cnt_nxt_s;
      logic                fire_s;

      // Next-state rule: refractory countdown, else leak+integrate with threshold test.
      always_comb begin
         sum_s       = sat_add(bus.current[i*WIDTH +: WIDTH], state_r >> leak_r);
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
         fire_s      = 1'b0;
         if (!bus.en) begin
            state_nxt_s = state_r;
         end else if (cnt_r != {REFRAC_W{1'b0}}) begin
            cnt_nxt_s = cnt_r - REFRAC_W'(1);
         end else if (sum_s >= thresh_r) begin
            fire_s      = 1'b1;
            cnt_nxt_s   = refrac_r;
            state_nxt_s = mode_r ? (sum_s - thresh_r) : {WIDTH{1'b0}};
         end else begin
            state_nxt_s = sum_s;
         end
      end

      // Per-neuron membrane, refractory counter and spike registers.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_r <= {WIDTH{1'b0}};
            cnt_r   <= {REFRAC_W{1'b0}};
            spike_r <= 1'b0;
         end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            spike_r <= fire_s;
         end
      end

      assign spike_nxt_s[i]                  = fire_s;
      assign bus.state[i*WIDTH +: WIDTH]     = state_r;
      assign bus.spike[i]                    = spike_r;
   end

   // Aggregate spike flag registered in step with the per-neuron spikes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spike_any_r <= 1'b0;
      end else begin
         spike_any_r <= |spike_nxt_s;
      end
   end

   assign bus.spike_any = spike_any_r;

endmodule
